mem_ctrl: RTL and testbench
===========================

Name: mem_ctrl

Overview:
- Byte-serial memory controller between the 8-bit RAM/IO bus and the CPU's two memory clients.
- Clients: the instruction fetcher (32-bit fetch reads) and the load/store buffer (1/2/4-byte loads and stores).
- It is the only driver of mem_a, mem_dout and mem_wr. It arbitrates between the clients, serialises accesses into little-endian byte transfers, and stalls IO writes while the UART buffer is full.

Parameters:
ADDR_WIDTH, 32, width of all address ports and mem_a

Ports:
clk  input  1  system clock
rst  input  1  reset, asynchronous, active-high
rdy  input  1  global ready; low freezes the block
mem_din  input  8  RAM/IO read data, valid the cycle after its address is driven
mem_dout  output  8  write data byte
mem_a  output  ADDR_WIDTH  byte address
mem_wr  output  1  1 = write, 0 = read
io_buffer_full  input  1  UART tx buffer full
flush  input  1  misprediction flush; aborts an instruction fetch
if_req  input  1  fetch request, level, held until if_done
if_addr  input  ADDR_WIDTH  fetch address
if_done  output  1  one-cycle pulse: if_inst valid
if_inst  output  32  fetched word
lsb_req  input  1  load/store request, level, held until lsb_done
lsb_wr  input  1  1 = store, 0 = load
lsb_addr  input  ADDR_WIDTH  access address
lsb_size  input  3  bytes to access: 1, 2 or 4; any other value is treated as 4
lsb_wdata  input  32  store data, low bytes used
lsb_done  output  1  one-cycle pulse: access complete, lsb_rdata valid for loads
lsb_rdata  input-free output  32  load data, zero-extended

Behaviour:
- Reset (async, rst=1) clears all registers.
  - State = IDLE.
  - mem_a = 0, mem_dout = 0, mem_wr = 0.
  - if_done = 0, lsb_done = 0, if_inst = 0, lsb_rdata = 0.
  - Byte counter = 0.
- rdy=0: no register changes. Outputs hold their values, including any done pulse.
- All outputs are registered.
- States: IDLE, IFETCH, LOAD, STORE.
- IDLE acceptance:
  - If a done pulse is being driven this cycle, no request is accepted (cooldown cycle).
  - Otherwise lsb_req has priority over if_req.
  - if_req is ignored in any cycle where flush=1.
  - On acceptance, address, size, write data and direction are latched. Later changes on the request inputs are ignored until done.
- Byte order: byte k of a transfer uses address base+k and bits [8k+7:8k].
- Read timing (IFETCH, LOAD), request accepted in cycle T:
  - Byte addresses base..base+n-1 are driven with mem_wr=0 in cycles T+1..T+n.
  - Byte k is captured from mem_din in cycle T+2+k.
  - The done pulse and the data appear in cycle T+n+2. State is IDLE in that cycle.
  - A 4-byte fetch is therefore visible at T+6.
- Write timing (STORE):
  - Bytes are written in cycles T+1..T+n with mem_wr=1 and mem_dout = byte k.
  - lsb_done is asserted in cycle T+n+1.
- IO stall:
  - Applies when the latched address has addr[17:16]==2'b11 and the access is a store.
  - If io_buffer_full=1 in a cycle, the next cycle drives mem_wr=0, mem_a=0, and the byte counter does not advance.
  - Writing resumes the cycle after io_buffer_full is seen low.
- Outputs when not transferring (IDLE, stall cycles, the final capture cycle of a read): mem_wr=0, mem_a=0, mem_dout=0.
- flush during IFETCH:
  - The state is IDLE the next cycle and if_done is never pulsed for that fetch.
  - Bytes already captured are discarded.
- flush has no effect on LOAD or STORE.
- Simultaneous if_req and lsb_req in IDLE: the LSB access is served first. The fetch waits; if_req stays high.
- if_inst and lsb_rdata hold their last values between done pulses.

Test Plan:
- Fetch, RAM holds 0x13,0x05,0x10,0x00 at 0x100; if_req, if_addr=0x100 accepted at T:
  - mem_a = 0x100..0x103 in T+1..T+4, mem_wr=0.
  - if_done=1 with if_inst=0x00100513 at T+6 only.
- Load size 2 at 0x200 (bytes 0xAB,0xCD):
  - lsb_done at T+4, lsb_rdata=0x0000CDAB.
  - Load size 1 returns 0x000000AB at T+3.
- Store size 4 of 0xDEADBEEF to 0x300:
  - mem_wr=1 for T+1..T+4 with mem_dout EF,BE,AD,DE at 0x300..0x303.
  - lsb_done at T+5.
- Store size 1 of 0x41 to 0x30000 with io_buffer_full=1 for 3 cycles from T:
  - No write while stalled (mem_wr=0).
  - Single write of 0x41 after io_buffer_full falls.
  - lsb_done the cycle after the write.
- if_req and lsb_req raised together:
  - LSB load served first.
  - Fetch accepted on the cycle after lsb_done; if_done 6 cycles later.
- flush at T+3 of a fetch:
  - State IDLE at T+4; no if_done.
  - New if_req at 0x400 fetches correctly.
- rdy low for 5 cycles mid-fetch: every output frozen; completion is delayed by exactly 5 cycles.
- rst mid-store: all outputs are 0 immediately (asynchronously).

Source files
------------

// File: rtl/mem_ctrl.sv
// mem_ctrl: byte-serial controller between the 8-bit RAM/IO bus and the two
// CPU memory clients (instruction fetcher and load/store buffer). It
// arbitrates between them (LSB first), splits each access into little-endian
// byte transfers, and holds IO stores while the UART tx buffer is full.
module mem_ctrl #(
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rdy,
  input  logic [7:0]            mem_din,
  output logic [7:0]            mem_dout,
  output logic [ADDR_WIDTH-1:0] mem_a,
  output logic                  mem_wr,
  input  logic                  io_buffer_full,
  input  logic                  flush,
  input  logic                  if_req,
  input  logic [ADDR_WIDTH-1:0] if_addr,
  output logic                  if_done,
  output logic [31:0]           if_inst,
  input  logic                  lsb_req,
  input  logic                  lsb_wr,
  input  logic [ADDR_WIDTH-1:0] lsb_addr,
  input  logic [2:0]            lsb_size,
  input  logic [31:0]           lsb_wdata,
  output logic                  lsb_done,
  output logic [31:0]           lsb_rdata
);

  typedef enum logic [1:0] {IDLE, IFETCH, LOAD, STORE} state_t;

  state_t                state_r, state_nxt;
  logic [2:0]            cnt_r, cnt_nxt;     // bytes issued (reads) / written (stores)
  logic [2:0]            len_r, len_nxt;     // transfer length in bytes
  logic [ADDR_WIDTH-1:0] base_r, base_nxt;
  logic [31:0]           wdata_r, wdata_nxt;
  logic [31:0]           acc_r, acc_nxt;     // read bytes gathered so far
  logic                  io_r, io_nxt;       // latched access targets the IO window
  logic [ADDR_WIDTH-1:0] mem_a_nxt;
  logic [7:0]            mem_dout_nxt;
  logic                  mem_wr_nxt;
  logic                  if_done_nxt, lsb_done_nxt;
  logic [31:0]           if_inst_nxt, lsb_rdata_nxt;
  logic [1:0]            cap_idx;
  logic [31:0]           acc_cap;
  logic                  lsb_io;

  // Sizes other than 1 and 2 are treated as a full word.
  function automatic logic [2:0] size_len(input logic [2:0] size);
    case (size)
      3'd1:    return 3'd1;
      3'd2:    return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

  function automatic logic [7:0] byte_sel(input logic [31:0] w, input logic [1:0] idx);
    return w[{idx, 3'b000} +: 8];
  endfunction

  // mem_din lags its address by one cycle, so while cnt_r bytes have been
  // issued the bus carries byte cnt_r-2.
  assign cap_idx = cnt_r[1:0] - 2'd2;
  assign acc_cap = acc_r | (32'(mem_din) << {cap_idx, 3'b000});
  assign lsb_io  = (lsb_addr[17:16] == 2'b11);

  // Next-state and next-output logic; every output is registered.
  always_comb begin
    state_nxt     = state_r;
    cnt_nxt       = cnt_r;
    len_nxt       = len_r;
    base_nxt      = base_r;
    wdata_nxt     = wdata_r;
    acc_nxt       = acc_r;
    io_nxt        = io_r;
    mem_a_nxt     = '0;
    mem_dout_nxt  = 8'h00;
    mem_wr_nxt    = 1'b0;
    if_done_nxt   = 1'b0;
    lsb_done_nxt  = 1'b0;
    if_inst_nxt   = if_inst;
    lsb_rdata_nxt = lsb_rdata;
    unique case (state_r)
      IDLE: begin
        // A visible done pulse makes this a cooldown cycle.
        if (!if_done && !lsb_done) begin
          if (lsb_req) begin
            base_nxt  = lsb_addr;
            len_nxt   = size_len(lsb_size);
            wdata_nxt = lsb_wdata;
            acc_nxt   = '0;
            io_nxt    = lsb_io;
            if (lsb_wr) begin
              state_nxt = STORE;
              if (lsb_io && io_buffer_full) begin
                cnt_nxt = 3'd0;
              end else begin
                mem_wr_nxt   = 1'b1;
                mem_a_nxt    = lsb_addr;
                mem_dout_nxt = lsb_wdata[7:0];
                cnt_nxt      = 3'd1;
              end
            end else begin
              state_nxt = LOAD;
              mem_a_nxt = lsb_addr;
              cnt_nxt   = 3'd1;
            end
          end else if (if_req && !flush) begin
            state_nxt = IFETCH;
            base_nxt  = if_addr;
            len_nxt   = 3'd4;
            acc_nxt   = '0;
            io_nxt    = 1'b0;
            mem_a_nxt = if_addr;
            cnt_nxt   = 3'd1;
          end
        end
      end
      IFETCH, LOAD: begin
        if (state_r == IFETCH && flush) begin
          state_nxt = IDLE;
          cnt_nxt   = 3'd0;
        end else begin
          cnt_nxt = cnt_r + 3'd1;
          if (cnt_r < len_r) mem_a_nxt = base_r + ADDR_WIDTH'(cnt_r);
          if (cnt_r >= 3'd2) acc_nxt = acc_cap;
          if (cnt_r == len_r + 3'd1) begin
            state_nxt = IDLE;
            cnt_nxt   = 3'd0;
            if (state_r == IFETCH) begin
              if_done_nxt = 1'b1;
              if_inst_nxt = acc_cap;
            end else begin
              lsb_done_nxt  = 1'b1;
              lsb_rdata_nxt = acc_cap;
            end
          end
        end
      end
      STORE: begin
        if (cnt_r == len_r) begin
          state_nxt    = IDLE;
          cnt_nxt      = 3'd0;
          lsb_done_nxt = 1'b1;
        end else if (!(io_r && io_buffer_full)) begin
          mem_wr_nxt   = 1'b1;
          mem_a_nxt    = base_r + ADDR_WIDTH'(cnt_r);
          mem_dout_nxt = byte_sel(wdata_r, cnt_r[1:0]);
          cnt_nxt      = cnt_r + 3'd1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State and output registers; rdy low freezes everything.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r   <= IDLE;
      cnt_r     <= 3'd0;
      len_r     <= 3'd0;
      base_r    <= '0;
      wdata_r   <= '0;
      acc_r     <= '0;
      io_r      <= 1'b0;
      mem_a     <= '0;
      mem_dout  <= 8'h00;
      mem_wr    <= 1'b0;
      if_done   <= 1'b0;
      lsb_done  <= 1'b0;
      if_inst   <= '0;
      lsb_rdata <= '0;
    end else if (rdy) begin
      state_r   <= state_nxt;
      cnt_r     <= cnt_nxt;
      len_r     <= len_nxt;
      base_r    <= base_nxt;
      wdata_r   <= wdata_nxt;
      acc_r     <= acc_nxt;
      io_r      <= io_nxt;
      mem_a     <= mem_a_nxt;
      mem_dout  <= mem_dout_nxt;
      mem_wr    <= mem_wr_nxt;
      if_done   <= if_done_nxt;
      lsb_done  <= lsb_done_nxt;
      if_inst   <= if_inst_nxt;
      lsb_rdata <= lsb_rdata_nxt;
    end
  end

endmodule

// File: tb/tb_mem_ctrl.sv
// tb_mem_ctrl: bench for mem_ctrl. A byte RAM answers the bus one cycle
// after each address; a transaction-level model predicts every output on
// every cycle, and directed sequences pin literal values.
module tb_mem_ctrl;
  localparam int AW = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          rdy = 1'b1;
  logic [7:0]    mem_din;
  logic [7:0]    mem_dout;
  logic [AW-1:0] mem_a;
  logic          mem_wr;
  logic          io_buffer_full = 1'b0;
  logic          flush = 1'b0;
  logic          if_req = 1'b0;
  logic [AW-1:0] if_addr = '0;
  logic          if_done;
  logic [31:0]   if_inst;
  logic          lsb_req = 1'b0;
  logic          lsb_wr = 1'b0;
  logic [AW-1:0] lsb_addr = '0;
  logic [2:0]    lsb_size = 3'd4;
  logic [31:0]   lsb_wdata = '0;
  logic          lsb_done;
  logic [31:0]   lsb_rdata;

  mem_ctrl #(.ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .mem_din(mem_din), .mem_dout(mem_dout),
    .mem_a(mem_a), .mem_wr(mem_wr), .io_buffer_full(io_buffer_full), .flush(flush),
    .if_req(if_req), .if_addr(if_addr), .if_done(if_done), .if_inst(if_inst),
    .lsb_req(lsb_req), .lsb_wr(lsb_wr), .lsb_addr(lsb_addr), .lsb_size(lsb_size),
    .lsb_wdata(lsb_wdata), .lsb_done(lsb_done), .lsb_rdata(lsb_rdata)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;
  logic chk_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) $display("FAIL %s: got %h, expected %h", name, act, exp);
    else n_pass++;
  endtask

  function automatic logic [7:0] seed_byte(input int i);
    case (i)
      'h100: return 8'h13;
      'h101: return 8'h05;
      'h102: return 8'h10;
      'h103: return 8'h00;
      'h200: return 8'hAB;
      'h201: return 8'hCD;
      'h400: return 8'h93;
      'h401: return 8'h08;
      'h402: return 8'h50;
      'h403: return 8'h00;
      default: return 8'((i * 29) ^ (i >> 7) ^ 32'h5A);
    endcase
  endfunction

  // Bus-side memory: answers one cycle after the address, stalls with rdy.
  logic [7:0] ram [0:65535];
  initial begin
    for (int i = 0; i < 65536; i++) ram[i] = seed_byte(i);
    mem_din = 8'h00;
    forever begin
      @(posedge clk);
      if (!rst && rdy) begin
        mem_din <= ram[mem_a[15:0]];
        if (mem_wr) ram[mem_a[15:0]] = mem_dout;
      end
    end
  end

  // ---------------- transaction-level reference model ----------------
  typedef struct packed {
    logic [31:0] a;
    logic [7:0]  d;
    logic        wr;
    logic        ifd;
    logic        lsbd;
    logic        upd;
    logic [31:0] data;
  } act_t;

  act_t        q[$];            // outputs for coming active cycles
  logic [7:0]  mram [0:65535];
  int          m_kind;          // 0 fetch, 1 load, 2 store
  logic        m_io;
  logic [31:0] e_a, e_inst, e_rdata;
  logic [7:0]  e_dout;
  logic        e_wr, e_ifd, e_lsbd;

  task automatic push_reads(input logic [31:0] base, input int n, input logic is_fetch);
    act_t e;
    logic [31:0] ak, data;
    data = '0;
    for (int k = 0; k < n; k++) begin
      ak = base + 32'(k);
      data = data | (32'(mram[ak[15:0]]) << (8 * k));
      e = '0;
      e.a = ak;
      q.push_back(e);
    end
    e = '0;
    q.push_back(e);
    e.upd = 1'b1;
    e.data = data;
    if (is_fetch) e.ifd = 1'b1; else e.lsbd = 1'b1;
    q.push_back(e);
  endtask

  task automatic model_accept();
    act_t e;
    logic [31:0] ak;
    int n;
    if (lsb_req) begin
      n = (lsb_size == 3'd1) ? 1 : (lsb_size == 3'd2) ? 2 : 4;
      if (lsb_wr) begin
        m_kind = 2;
        m_io = (lsb_addr[17:16] == 2'b11);
        for (int k = 0; k < n; k++) begin
          ak = lsb_addr + 32'(k);
          e = '0;
          e.a = ak;
          e.wr = 1'b1;
          e.d = lsb_wdata[8*k +: 8];
          mram[ak[15:0]] = e.d;
          q.push_back(e);
        end
        e = '0;
        e.lsbd = 1'b1;
        q.push_back(e);
      end else begin
        m_kind = 1;
        m_io = 1'b0;
        push_reads(lsb_addr, n, 1'b0);
      end
    end else if (if_req && !flush) begin
      m_kind = 0;
      m_io = 1'b0;
      push_reads(if_addr, 4, 1'b1);
    end
  endtask

  task automatic model_step();
    act_t nx;
    nx = '0;
    if (q.size() == 0) begin
      if (!(e_ifd || e_lsbd)) model_accept();
    end else if (m_kind == 0 && flush) begin
      q.delete();
    end
    if (q.size() != 0) begin
      if (!(m_kind == 2 && m_io && io_buffer_full && q[0].wr)) nx = q.pop_front();
    end
    e_a = nx.a;
    e_dout = nx.d;
    e_wr = nx.wr;
    e_ifd = nx.ifd;
    e_lsbd = nx.lsbd;
    if (nx.upd && nx.ifd) e_inst = nx.data;
    if (nx.upd && nx.lsbd) e_rdata = nx.data;
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) mram[i] = seed_byte(i);
    m_kind = 0; m_io = 1'b0;
    e_a = '0; e_dout = '0; e_wr = 1'b0; e_ifd = 1'b0; e_lsbd = 1'b0; e_inst = '0; e_rdata = '0;
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        q.delete();
        e_a = '0; e_dout = '0; e_wr = 1'b0; e_ifd = 1'b0; e_lsbd = 1'b0; e_inst = '0; e_rdata = '0;
      end else if (rdy) begin
        model_step();
      end
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  initial forever begin
    @(negedge clk);
    if (chk_en) begin
      chk("mem_a", mem_a, e_a);
      chk("mem_dout", 32'(mem_dout), 32'(e_dout));
      chk("mem_wr", 32'(mem_wr), 32'(e_wr));
      chk("if_done", 32'(if_done), 32'(e_ifd));
      chk("lsb_done", 32'(lsb_done), 32'(e_lsbd));
      chk("if_inst", if_inst, e_inst);
      chk("lsb_rdata", lsb_rdata, e_rdata);
    end
  end

  // ---------------- stimulus ----------------
  logic [31:0] w;
  logic [31:0] snap_a;
  logic        snap_wr;
  int          n_lsb_dones = 0;
  int          n_if_dones = 0;

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_mem_a", mem_a, 32'h0);
    chk("rst_mem_wr", 32'(mem_wr), 32'h0);
    chk("rst_mem_dout", 32'(mem_dout), 32'h0);
    chk("rst_if_done", 32'(if_done), 32'h0);
    chk("rst_lsb_done", 32'(lsb_done), 32'h0);
    chk("rst_if_inst", if_inst, 32'h0);
    chk("rst_lsb_rdata", lsb_rdata, 32'h0);
    rst = 1'b0;
    chk_en = 1'b1;
    repeat (2) @(negedge clk);

    // Fetch of 0x00100513 from 0x100.
    if_addr = 32'h100; if_req = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      if (k <= 4) chk("fetch_a", mem_a, 32'h100 + 32'(k - 1));
      chk("fetch_wr", 32'(mem_wr), 32'h0);
      chk("fetch_done", 32'(if_done), 32'(k == 6));
      if (k == 6) begin chk("fetch_inst", if_inst, 32'h00100513); if_req = 1'b0; end
    end
    repeat (2) @(negedge clk);

    // Loads of size 2 and 1 from 0x200.
    lsb_addr = 32'h200; lsb_wr = 1'b0; lsb_size = 3'd2; lsb_req = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      chk("ld2_done", 32'(lsb_done), 32'(k == 4));
      if (k == 4) begin chk("ld2_rdata", lsb_rdata, 32'h0000CDAB); lsb_req = 1'b0; end
    end
    repeat (2) @(negedge clk);
    lsb_size = 3'd1; lsb_req = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      chk("ld1_done", 32'(lsb_done), 32'(k == 3));
      if (k == 3) begin chk("ld1_rdata", lsb_rdata, 32'h000000AB); lsb_req = 1'b0; end
    end
    repeat (2) @(negedge clk);

    // Word store of 0xDEADBEEF to 0x300.
    w = 32'hDEADBEEF;
    lsb_addr = 32'h300; lsb_wr = 1'b1; lsb_size = 3'd4; lsb_wdata = w; lsb_req = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      chk("st4_wr", 32'(mem_wr), 32'(k <= 4));
      if (k <= 4) begin
        chk("st4_a", mem_a, 32'h300 + 32'(k - 1));
        chk("st4_dout", 32'(mem_dout), 32'(w[8*(k-1) +: 8]));
      end
      chk("st4_done", 32'(lsb_done), 32'(k == 5));
      if (k == 5) lsb_req = 1'b0;
    end
    repeat (2) @(negedge clk);

    // IO byte store while the UART buffer is full for three cycles.
    lsb_addr = 32'h30000; lsb_wr = 1'b1; lsb_size = 3'd1; lsb_wdata = 32'h41;
    lsb_req = 1'b1; io_buffer_full = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      if (k == 3) io_buffer_full = 1'b0;
      chk("io_wr", 32'(mem_wr), 32'(k == 4));
      if (k == 4) begin
        chk("io_a", mem_a, 32'h30000);
        chk("io_dout", 32'(mem_dout), 32'h41);
      end
      chk("io_done", 32'(lsb_done), 32'(k == 5));
      if (k == 5) lsb_req = 1'b0;
    end
    repeat (2) @(negedge clk);

    // Simultaneous requests: load first, fetch the cycle after lsb_done.
    lsb_addr = 32'h200; lsb_wr = 1'b0; lsb_size = 3'd1; lsb_req = 1'b1;
    if_addr = 32'h100; if_req = 1'b1;
    for (int k = 1; k <= 11; k++) begin
      @(negedge clk);
      chk("both_lsb_done", 32'(lsb_done), 32'(k == 3));
      if (k == 3) begin chk("both_rdata", lsb_rdata, 32'hAB); lsb_req = 1'b0; end
      if (k == 4) chk("both_idle_a", mem_a, 32'h0);
      if (k == 5) chk("both_fetch_a", mem_a, 32'h100);
      chk("both_if_done", 32'(if_done), 32'(k == 10));
      if (k == 10) begin chk("both_inst", if_inst, 32'h00100513); if_req = 1'b0; end
    end
    repeat (2) @(negedge clk);

    // Flush at T+3 of a fetch, redirect to 0x400.
    if_addr = 32'h100; if_req = 1'b1;
    for (int k = 1; k <= 11; k++) begin
      @(negedge clk);
      if (k == 3) begin flush = 1'b1; if_addr = 32'h400; end
      if (k == 4) begin flush = 1'b0; chk("flush_idle_a", mem_a, 32'h0); end
      if (k == 5) chk("flush_new_a", mem_a, 32'h400);
      chk("flush_if_done", 32'(if_done), 32'(k == 10));
      if (k == 10) begin chk("flush_inst", if_inst, 32'h00500893); if_req = 1'b0; end
    end
    repeat (2) @(negedge clk);

    // rdy low for five cycles in the middle of a fetch.
    if_addr = 32'h100; if_req = 1'b1;
    snap_a = '0; snap_wr = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (k == 2) begin rdy = 1'b0; snap_a = mem_a; snap_wr = mem_wr; end
      if (k >= 3 && k <= 7) begin
        chk("rdy_hold_a", mem_a, snap_a);
        chk("rdy_hold_wr", 32'(mem_wr), 32'(snap_wr));
      end
      if (k == 7) rdy = 1'b1;
      chk("rdy_if_done", 32'(if_done), 32'(k == 11));
      if (k == 11) begin chk("rdy_inst", if_inst, 32'h00100513); if_req = 1'b0; end
    end
    chk("rdy_snap_a", snap_a, 32'h101);
    repeat (2) @(negedge clk);

    // Asynchronous reset in the middle of a store (same data as already stored).
    lsb_addr = 32'h300; lsb_wr = 1'b1; lsb_size = 3'd4; lsb_wdata = 32'hDEADBEEF; lsb_req = 1'b1;
    repeat (2) @(negedge clk);
    chk("prerst_wr", 32'(mem_wr), 32'h1);
    lsb_req = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("arst_mem_a", mem_a, 32'h0);
    chk("arst_mem_wr", 32'(mem_wr), 32'h0);
    chk("arst_mem_dout", 32'(mem_dout), 32'h0);
    chk("arst_if_inst", if_inst, 32'h0);
    chk("arst_lsb_rdata", lsb_rdata, 32'h0);
    @(negedge clk);
    #2 rst = 1'b0;
    repeat (2) @(negedge clk);

    // Randomized traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      rdy = ($urandom_range(0, 9) != 0);
      io_buffer_full = ($urandom_range(0, 3) == 0);
      flush = ($urandom_range(0, 19) == 0);
      if (lsb_req && lsb_done) begin
        lsb_req = 1'b0;
        n_lsb_dones++;
      end else if (!lsb_req && $urandom_range(0, 3) == 0) begin
        lsb_req = 1'b1;
        lsb_wr = $urandom_range(0, 1) == 1;
        lsb_addr = $urandom & 32'h0003_FFFF;
        lsb_size = 3'($urandom_range(0, 7));
        lsb_wdata = $urandom;
      end
      if (if_req && if_done) begin
        if_req = 1'b0;
        n_if_dones++;
      end else if (!if_req && $urandom_range(0, 3) == 0) begin
        if_req = 1'b1;
        if_addr = $urandom & 32'h0003_FFFF;
      end else if (if_req && flush) begin
        if_addr = $urandom & 32'h0003_FFFF;
      end
    end
    lsb_req = 1'b0; if_req = 1'b0; rdy = 1'b1; flush = 1'b0; io_buffer_full = 1'b0;
    repeat (20) @(negedge clk);
    chk("rand_lsb_progress", 32'(n_lsb_dones > 20), 32'h1);
    chk("rand_if_progress", 32'(n_if_dones > 20), 32'h1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
